// File: rtl/ddr3_fb_pkg.sv
// ddr3_fb_pkg: shared types, bank count and bank-to-address helper for the DDR3 frame arbiter.
// Build option: DDR3_TRIPLE_BUF_EN selects three frame banks instead of two.
package ddr3_fb_pkg;
`ifdef DDR3_TRIPLE_BUF_EN
    localparam int NUM_BANKS = 3;
`else
    localparam int NUM_BANKS = 2;
`endif
    localparam int BANK_W = 2;
    localparam int AW_MAX = 64;
    typedef logic [BANK_W-1:0] bank_t;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_ACTIVE} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_ACTIVE} rd_state_t;
    // Computed wide; callers truncate to their address width, which gives the same unsigned wrap.
    function automatic logic [AW_MAX-1:0] bank_addr(input logic [AW_MAX-1:0] base,
                                                    input logic [AW_MAX-1:0] stride,
                                                    input bank_t bank);
        return base + stride * {{(AW_MAX-BANK_W){1'b0}}, bank};
    endfunction
endpackage

// File: rtl/ddr3_bank_alloc.sv
// ddr3_bank_alloc: combinational free-bank selector, lowest index not held by the reader or the last frame.
// Ports: rd_busy/rd_bank (reader occupancy), last_vld/last_bank (newest completed frame),
//        alloc_ok (a bank is free), alloc_bank (chosen bank).
module ddr3_bank_alloc
    import ddr3_fb_pkg::*;
(
    input  logic  rd_busy,
    input  bank_t rd_bank,
    input  logic  last_vld,
    input  bank_t last_bank,
    output logic  alloc_ok,
    output bank_t alloc_bank
);
    // Scan from the top down so the lowest free index is the one left standing.
    always_comb begin
        alloc_ok   = 1'b0;
        alloc_bank = '0;
        for (int b = NUM_BANKS - 1; b >= 0; b--) begin
            if (!(rd_busy && rd_bank == BANK_W'(b)) && !(last_vld && last_bank == BANK_W'(b))) begin
                alloc_ok   = 1'b1;
                alloc_bank = BANK_W'(b);
            end
        end
    end
endmodule

// File: rtl/ddr3_frame_arbiter.sv
// ddr3_frame_arbiter: schedules DDR3 frame banks between one image writer and one image reader.
// Ports: clk, rst_n (sync active-low), init_calib_complete (low = soft reset);
//        wr/rd_frame_start/done pulses in; wr_req/rd_req one-cycle requests with begin/end addresses;
//        wr_bank/rd_bank, frame_vld, wr_drop/rd_empty pulses, saturating drop_cnt.
// Build option: DDR3_TRIPLE_BUF_EN (three banks) via ddr3_fb_pkg.
module ddr3_frame_arbiter
    import ddr3_fb_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 28,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(28'h100_0000),
    parameter logic [ADDR_WIDTH-1:0] BANK_STRIDE = ADDR_WIDTH'(28'h10_0000),
    parameter logic [ADDR_WIDTH-1:0] FRAME_SIZE  = ADDR_WIDTH'(28'h7_5300)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_calib_complete,
    input  logic                  wr_frame_start,
    input  logic                  wr_frame_done,
    input  logic                  rd_frame_start,
    input  logic                  rd_frame_done,
    output logic                  wr_req,
    output logic [ADDR_WIDTH-1:0] wr_address_beign,
    output logic [ADDR_WIDTH-1:0] wr_address_end,
    output logic                  rd_req,
    output logic [ADDR_WIDTH-1:0] rd_address_beign,
    output logic [ADDR_WIDTH-1:0] rd_address_end,
    output logic [1:0]            wr_bank,
    output logic [1:0]            rd_bank,
    output logic                  frame_vld,
    output logic                  wr_drop,
    output logic                  rd_empty,
    output logic [15:0]           drop_cnt
);
    localparam logic [AW_MAX-1:0] BASE_W   = AW_MAX'(BASE_ADDR);
    localparam logic [AW_MAX-1:0] STRIDE_W = AW_MAX'(BANK_STRIDE);
    wr_state_t wr_q, wr_d;
    rd_state_t rd_q, rd_d;
    logic last_vld_q, last_vld_d, wr_drop_q, wr_drop_d, rd_empty_q, rd_empty_d;
    bank_t last_bank_q, last_bank_d, wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [ADDR_WIDTH-1:0] wr_beg_q, wr_beg_d, wr_end_q, wr_end_d;
    logic [ADDR_WIDTH-1:0] rd_beg_q, rd_beg_d, rd_end_q, rd_end_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic wr_done, wr_start, rd_start, rd_busy, last_vld_e, alloc_ok, wr_acc, rd_acc;
    bank_t last_bank_e, alloc_bank;
    ddr3_bank_alloc u_alloc (
        .rd_busy   (rd_busy),
        .rd_bank   (rd_bank_q),
        .last_vld  (last_vld_e),
        .last_bank (last_bank_e),
        .alloc_ok  (alloc_ok),
        .alloc_bank(alloc_bank)
    );
    always_comb begin
        wr_done     = (wr_q == W_ACTIVE) && wr_frame_done;
        wr_start    = (wr_q != W_REQ) && wr_frame_start;
        rd_start    = (rd_q == R_IDLE) && rd_frame_start;
        // A frame completing this cycle is already visible to the reader and to allocation.
        last_vld_e  = last_vld_q || wr_done;
        last_bank_e = wr_done ? wr_bank_q : last_bank_q;
        // A reader finishing this cycle releases its bank to a simultaneous write start.
        rd_busy     = (rd_q == R_REQ) || (rd_q == R_ACTIVE && !rd_frame_done);
        wr_acc      = wr_start && alloc_ok;
        rd_acc      = rd_start && last_vld_e;
        wr_d        = wr_acc ? W_REQ : (wr_start || wr_done) ? W_IDLE : (wr_q == W_REQ) ? W_ACTIVE : wr_q;
        rd_d        = rd_acc ? R_REQ : (rd_q == R_REQ) ? R_ACTIVE : (rd_q == R_ACTIVE && rd_frame_done) ? R_IDLE : rd_q;
        last_vld_d  = last_vld_e;
        last_bank_d = last_bank_e;
        wr_bank_d   = wr_acc ? alloc_bank : wr_bank_q;
        rd_bank_d   = rd_acc ? last_bank_e : rd_bank_q;
        wr_beg_d    = wr_acc ? ADDR_WIDTH'(bank_addr(BASE_W, STRIDE_W, alloc_bank)) : wr_beg_q;
        wr_end_d    = wr_acc ? wr_beg_d + FRAME_SIZE : wr_end_q;
        rd_beg_d    = rd_acc ? ADDR_WIDTH'(bank_addr(BASE_W, STRIDE_W, last_bank_e)) : rd_beg_q;
        rd_end_d    = rd_acc ? rd_beg_d + FRAME_SIZE : rd_end_q;
        // An abort always drops, even if reallocation then succeeds.
        wr_drop_d   = wr_start && (!alloc_ok || (wr_q == W_ACTIVE));
        rd_empty_d  = rd_start && !last_vld_e;
        drop_cnt_d  = drop_cnt_q + {15'd0, wr_drop_d && drop_cnt_q != 16'hFFFF};
    end
    always_ff @(posedge clk) begin
        if (!rst_n || !init_calib_complete) begin
            wr_q        <= W_IDLE;
            rd_q        <= R_IDLE;
            last_vld_q  <= 1'b0;
            last_bank_q <= '0;
            wr_bank_q   <= '0;
            rd_bank_q   <= '0;
            wr_beg_q    <= '0;
            wr_end_q    <= '0;
            rd_beg_q    <= '0;
            rd_end_q    <= '0;
            wr_drop_q   <= 1'b0;
            rd_empty_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            last_vld_q  <= last_vld_d;
            last_bank_q <= last_bank_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_beg_q    <= wr_beg_d;
            wr_end_q    <= wr_end_d;
            rd_beg_q    <= rd_beg_d;
            rd_end_q    <= rd_end_d;
            wr_drop_q   <= wr_drop_d;
            rd_empty_q  <= rd_empty_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end
    assign wr_req           = (wr_q == W_REQ);
    assign rd_req           = (rd_q == R_REQ);
    assign wr_address_beign = wr_beg_q;
    assign wr_address_end   = wr_end_q;
    assign rd_address_beign = rd_beg_q;
    assign rd_address_end   = rd_end_q;
    assign wr_bank          = wr_bank_q;
    assign rd_bank          = rd_bank_q;
    assign frame_vld        = last_vld_q;
    assign wr_drop          = wr_drop_q;
    assign rd_empty         = rd_empty_q;
    assign drop_cnt         = drop_cnt_q;
endmodule
